// File: rtl/jpeg_bit_packer.sv
// JPEG entropy-code bit packer: concatenates variable-length codes MSB-first
// into 32-bit words, and on request pads to a byte boundary and appends 0xFF
// fill plus a 2-byte marker so the marker ends exactly on a word boundary.
module jpeg_bit_packer #(
  parameter int unsigned MAXLEN = 27
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [4:0]        in_len,
  input  logic [MAXLEN-1:0] in_bits,
  input  logic              mark_valid,
  input  logic [7:0]        mark_code,
  output logic              ready,
  output logic              enqueue,
  output logic [31:0]       wdata,
  output logic [31:0]       wdata_nostuff
);

  typedef enum logic {PACK, MARK} state_t;

  state_t       state, state_nx;
  logic [63:0]  acc;
  logic [5:0]   fill;
  logic [95:0]  drain_data, drain_ns;
  logic [1:0]   words_left;

  logic         code_en, accept_mark;
  logic [63:0]  code64, comb_acc, padded;
  logic [6:0]   new_fill;
  logic [3:0]   nbytes, total_bytes, mark_pos;
  logic [1:0]   nfill, nwords;
  logic [95:0]  padded96, mark_data, mark_ns;

  assign ready = (state == PACK) && !rst;

  // Merge the incoming code into the accumulator and assemble the marker burst.
  always_comb begin
    code_en     = ready && in_valid && (in_len != 5'd0);
    accept_mark = ready && mark_valid;
    code64      = {{(64-MAXLEN){1'b0}}, in_bits} & ((64'd1 << in_len) - 64'd1);
    comb_acc    = acc;
    new_fill    = {1'b0, fill};
    if (code_en) begin
      comb_acc = acc | (code64 << (7'd64 - {1'b0, fill} - {2'b0, in_len}));
      new_fill = {1'b0, fill} + {2'b0, in_len};
    end
    nbytes      = 4'((new_fill + 7'd7) >> 3);
    // 1-bits from the current fill point up to the end of the last partial byte
    padded      = comb_acc | ((~64'd0 >> new_fill) & ~(~64'd0 >> {nbytes, 3'b000}));
    nfill       = 2'd2 - nbytes[1:0];
    total_bytes = nbytes + {2'b00, nfill} + 4'd2;
    nwords      = 2'(total_bytes >> 2);
    mark_pos    = nbytes + {2'b00, nfill} + 4'd1;
    padded96    = {padded, 32'hFFFF_FFFF};
    mark_data   = '0;
    mark_ns     = '0;
    for (int unsigned i = 0; i < 12; i++) begin
      if (4'(i) < nbytes) begin
        mark_data[95-8*i -: 8] = padded96[95-8*i -: 8];
      end else if (4'(i) < mark_pos) begin
        mark_data[95-8*i -: 8] = 8'hFF;
        mark_ns[95-8*i -: 8]   = 8'hFF;
      end else if (4'(i) == mark_pos) begin
        mark_data[95-8*i -: 8] = mark_code;
        mark_ns[95-8*i -: 8]   = 8'hFF;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= PACK;
    else     state <= state_nx;
  end

  // Next state: enter MARK on an accepted marker, leave once the drain is empty.
  always_comb begin
    state_nx = state;
    case (state)
      PACK:    if (accept_mark) state_nx = MARK;
      MARK:    if (words_left == 2'd0) state_nx = PACK;
      default: state_nx = PACK;
    endcase
  end

  // Accumulator, drain buffer and registered word outputs.
  // The first marker word is registered at the accepting edge so the burst
  // occupies exactly the W cycles in which ready is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc           <= '0;
      fill          <= '0;
      drain_data    <= '0;
      drain_ns      <= '0;
      words_left    <= '0;
      enqueue       <= 1'b0;
      wdata         <= '0;
      wdata_nostuff <= '0;
    end else if (state == PACK) begin
      if (accept_mark) begin
        enqueue       <= 1'b1;
        wdata         <= mark_data[95:64];
        wdata_nostuff <= mark_ns[95:64];
        drain_data    <= mark_data << 32;
        drain_ns      <= mark_ns << 32;
        words_left    <= nwords - 2'd1;
        acc           <= '0;
        fill          <= '0;
      end else if (code_en && new_fill >= 7'd32) begin
        enqueue       <= 1'b1;
        wdata         <= comb_acc[63:32];
        wdata_nostuff <= '0;
        acc           <= comb_acc << 32;
        fill          <= 6'(new_fill - 7'd32);
      end else begin
        enqueue <= 1'b0;
        acc     <= comb_acc;
        fill    <= 6'(new_fill);
      end
    end else begin
      if (words_left != 2'd0) begin
        enqueue       <= 1'b1;
        wdata         <= drain_data[95:64];
        wdata_nostuff <= drain_ns[95:64];
        drain_data    <= drain_data << 32;
        drain_ns      <= drain_ns << 32;
        words_left    <= words_left - 2'd1;
      end else begin
        enqueue <= 1'b0;
      end
    end
  end

`ifndef SYNTHESIS
  // Code lengths above MAXLEN have no defined meaning; stop the simulation.
  always_ff @(posedge clk) begin
    if (!rst && ready && in_valid && in_len > 5'(MAXLEN)) begin
      $display("jpeg_bit_packer: illegal in_len %0d", in_len);
      $finish;
    end
  end
`endif

endmodule
